// File: rtl/axi4l_to_wishbone_pkg.sv
// rtl/axi4l_to_wishbone_pkg.sv - shared state codes and response encodings for the AXI4-Lite to Wishbone bridge
package axi4l_to_wishbone_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WB_WRITE = 3'd1;
  localparam logic [2:0] ST_WB_READ  = 3'd2;
  localparam logic [2:0] ST_B_RESP   = 3'd3;
  localparam logic [2:0] ST_R_RESP   = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4l_to_wishbone_timer.sv
// rtl/axi4l_to_wishbone_timer.sv - clear/enable cycle counter flagging the last allowed strobe cycle
module axi4l_to_wishbone_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear has priority so a new strobe always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Expired during the LIMIT-th enabled cycle, so the owner drops its strobe on the next edge.
  assign expired = en && (count == LAST);

endmodule

// File: rtl/axi4l_to_wishbone_bridge.sv
// rtl/axi4l_to_wishbone_bridge.sv - single-outstanding AXI4-Lite slave to Wishbone classic master, optional AXI4L_TO_WISHBONE_TIMEOUT_EN
module axi4l_to_wishbone_bridge
  import axi4l_to_wishbone_pkg::*;
#(
  parameter int AXI4L_ADDR_WIDTH = 40,
  parameter int AXI4L_DATA_WIDTH = 64,
  parameter int AXI4L_STRB_WIDTH = AXI4L_DATA_WIDTH / 8,
  parameter int WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - $clog2(AXI4L_STRB_WIDTH),
  parameter int WB_DAT_WIDTH     = AXI4L_DATA_WIDTH,
  parameter int WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
  input  logic [2:0]                  s_axi4l_awprot,
  input  logic                        s_axi4l_awvalid,
  output logic                        s_axi4l_awready,
  input  logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_wdata,
  input  logic [AXI4L_STRB_WIDTH-1:0] s_axi4l_wstrb,
  input  logic                        s_axi4l_wvalid,
  output logic                        s_axi4l_wready,
  output logic [1:0]                  s_axi4l_bresp,
  output logic                        s_axi4l_bvalid,
  input  logic                        s_axi4l_bready,
  input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
  input  logic [2:0]                  s_axi4l_arprot,
  input  logic                        s_axi4l_arvalid,
  output logic                        s_axi4l_arready,
  output logic [AXI4L_DATA_WIDTH-1:0] s_axi4l_rdata,
  output logic [1:0]                  s_axi4l_rresp,
  output logic                        s_axi4l_rvalid,
  input  logic                        s_axi4l_rready,
  output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
  input  logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o,
  output logic                        m_wb_we_o,
  output logic                        m_wb_stb_o,
  input  logic                        m_wb_ack_i
);

  localparam int ADDR_LSB = $clog2(AXI4L_STRB_WIDTH);

  logic [2:0] state;
  logic       last_grant_rd;
  logic       wr_elig;
  logic       rd_elig;
  logic       grant_wr;
  logic       grant_rd;
  logic       timeout;
  logic       unused_ok;

  // Round-robin arbitration in IDLE: a tie goes to the channel not served last.
  always_comb begin
    wr_elig  = s_axi4l_awvalid && s_axi4l_wvalid;
    rd_elig  = s_axi4l_arvalid;
    grant_wr = (state == ST_IDLE) && wr_elig && (!rd_elig || last_grant_rd);
    grant_rd = (state == ST_IDLE) && rd_elig && (!wr_elig || !last_grant_rd);
  end

  // AW and W are only ever taken together, in the grant cycle.
  assign s_axi4l_awready = grant_wr;
  assign s_axi4l_wready  = grant_wr;
  assign s_axi4l_arready = grant_rd;

  // Protection bits and sub-word address bits have no meaning on this bus.
  assign unused_ok = ^{s_axi4l_awprot, s_axi4l_arprot,
                       s_axi4l_awaddr[ADDR_LSB-1:0], s_axi4l_araddr[ADDR_LSB-1:0]};

`ifdef AXI4L_TO_WISHBONE_TIMEOUT_EN
  axi4l_to_wishbone_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clr     (!m_wb_stb_o),
    .en      (m_wb_stb_o),
    .expired (timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  // Transaction FSM: latch the granted request, run one strobe/ack cycle, hold the response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= ST_IDLE;
      last_grant_rd  <= 1'b1;
      m_wb_adr_o     <= '0;
      m_wb_dat_o     <= '0;
      m_wb_sel_o     <= '0;
      m_wb_we_o      <= 1'b0;
      m_wb_stb_o     <= 1'b0;
      s_axi4l_rdata  <= '0;
      s_axi4l_bresp  <= RESP_OKAY;
      s_axi4l_rresp  <= RESP_OKAY;
      s_axi4l_bvalid <= 1'b0;
      s_axi4l_rvalid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            m_wb_adr_o    <= s_axi4l_awaddr[ADDR_LSB +: WB_ADR_WIDTH];
            m_wb_dat_o    <= s_axi4l_wdata;
            m_wb_sel_o    <= s_axi4l_wstrb;
            m_wb_we_o     <= 1'b1;
            m_wb_stb_o    <= 1'b1;
            last_grant_rd <= 1'b0;
            state         <= ST_WB_WRITE;
          end else if (grant_rd) begin
            m_wb_adr_o    <= s_axi4l_araddr[ADDR_LSB +: WB_ADR_WIDTH];
            m_wb_sel_o    <= '1;
            m_wb_we_o     <= 1'b0;
            m_wb_stb_o    <= 1'b1;
            last_grant_rd <= 1'b1;
            state         <= ST_WB_READ;
          end
        end
        ST_WB_WRITE: begin
          if (m_wb_ack_i || timeout) begin
            m_wb_stb_o     <= 1'b0;
            m_wb_we_o      <= 1'b0;
            s_axi4l_bresp  <= m_wb_ack_i ? RESP_OKAY : RESP_SLVERR;
            s_axi4l_bvalid <= 1'b1;
            state          <= ST_B_RESP;
          end
        end
        ST_WB_READ: begin
          if (m_wb_ack_i || timeout) begin
            m_wb_stb_o     <= 1'b0;
            s_axi4l_rdata  <= m_wb_ack_i ? m_wb_dat_i : '0;
            s_axi4l_rresp  <= m_wb_ack_i ? RESP_OKAY : RESP_SLVERR;
            s_axi4l_rvalid <= 1'b1;
            state          <= ST_R_RESP;
          end
        end
        ST_B_RESP: begin
          if (s_axi4l_bready) begin
            s_axi4l_bvalid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        ST_R_RESP: begin
          if (s_axi4l_rready) begin
            s_axi4l_rvalid <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_to_wishbone_bridge.sv
// tb/tb_axi4l_to_wishbone_bridge.sv - randomized and directed self-checking bench for the AXI4-Lite to Wishbone bridge
module tb_axi4l_to_wishbone_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [39:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [39:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [36:0] wb_adr;
  logic [63:0] wb_dat_i = '0;
  logic [63:0] wb_dat_o;
  logic [7:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  bit last_rd = 1'b1;

  logic [63:0] wb_mem  [logic [36:0]];
  logic [63:0] ref_mem [logic [36:0]];

  axi4l_to_wishbone_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi4l_awaddr(awaddr), .s_axi4l_awprot(awprot), .s_axi4l_awvalid(awvalid), .s_axi4l_awready(awready),
    .s_axi4l_wdata(wdata), .s_axi4l_wstrb(wstrb), .s_axi4l_wvalid(wvalid), .s_axi4l_wready(wready),
    .s_axi4l_bresp(bresp), .s_axi4l_bvalid(bvalid), .s_axi4l_bready(bready),
    .s_axi4l_araddr(araddr), .s_axi4l_arprot(arprot), .s_axi4l_arvalid(arvalid), .s_axi4l_arready(arready),
    .s_axi4l_rdata(rdata), .s_axi4l_rresp(rresp), .s_axi4l_rvalid(rvalid), .s_axi4l_rready(rready),
    .m_wb_adr_o(wb_adr), .m_wb_dat_i(wb_dat_i), .m_wb_dat_o(wb_dat_o), .m_wb_sel_o(wb_sel),
    .m_wb_we_o(wb_we), .m_wb_stb_o(wb_stb), .m_wb_ack_i(wb_ack)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mem_get(input logic [36:0] a, input bit use_ref);
    if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
    return wb_mem.exists(a) ? wb_mem[a] : 64'h0;
  endfunction

  // One full AXI transaction: request, Wishbone slave with lat wait cycles, response held bdly cycles.
  task automatic run_xact(input bit is_wr, input logic [39:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int lat, input int bdly);
    int n = 0;
    logic [63:0] exp_rd;
    logic [36:0] word = addr[39:3];
    if (is_wr) begin
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = addr; arvalid = 1'b1;
    end
    bready = 1'b0; rready = 1'b0;
    #1;
    while (!(is_wr ? awready : arready) && n < 20) begin @(posedge aclk); #2; n++; end
    chk("accept", 64'(is_wr ? awready : arready), 64'd1);
    if (is_wr) chk("wready_with_aw", 64'(wready), 64'd1);
    last_rd = !is_wr;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    #1;
    chk("stb_after_accept", 64'(wb_stb), 64'd1);
    chk("we", 64'(wb_we), 64'(is_wr));
    chk("adr", 64'(wb_adr), 64'(word));
    if (is_wr) begin
      chk("sel", 64'(wb_sel), 64'(strb));
      chk("dat_o", wb_dat_o, data);
    end
    for (int k = 0; k < lat; k++) begin
      @(posedge aclk); #2;
      chk("stb_wait", 64'(wb_stb), 64'd1);
    end
    if (wb_we) wb_mem[wb_adr] = merge(mem_get(wb_adr, 0), wb_dat_o, wb_sel);
    else wb_dat_i = mem_get(wb_adr, 0);
    wb_ack = 1'b1;
    @(posedge aclk); #1;
    wb_ack = 1'b0; wb_dat_i = {$urandom, $urandom};
    #1;
    chk("stb_drop", 64'(wb_stb), 64'd0);
    if (is_wr) begin
      ref_mem[word] = merge(mem_get(word, 1), data, strb);
      chk("bvalid", 64'(bvalid), 64'd1);
      chk("bresp", 64'(bresp), 64'd0);
    end else begin
      exp_rd = mem_get(word, 1);
      chk("rvalid", 64'(rvalid), 64'd1);
      chk("rresp", 64'(rresp), 64'd0);
      chk("rdata", rdata, exp_rd);
    end
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int k = 0; k < bdly; k++) begin
      @(posedge aclk); #2;
      chk("hold_valid", 64'(is_wr ? bvalid : rvalid), 64'd1);
      chk("hold_resp", 64'(is_wr ? bresp : rresp), 64'd0);
      if (!is_wr) chk("hold_rdata", rdata, exp_rd);
      chk("hold_no_accept", 64'({awready, arready}), 64'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    if (is_wr) bready = 1'b1; else rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    #1;
    chk("valid_cleared", 64'({bvalid, rvalid}), 64'd0);
  endtask

  // Both channels request together; the model expects the channel not granted last.
  task automatic tie_round(input logic [39:0] waddr, input logic [63:0] wd, input logic [39:0] raddr);
    bit exp_wr = last_rd;
    awaddr = waddr; wdata = wd; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = raddr; arvalid = 1'b1;
    #1;
    chk("tie_awready", 64'(awready), 64'(exp_wr));
    chk("tie_arready", 64'(arready), 64'(!exp_wr));
    if (exp_wr) begin
      arvalid = 1'b0;
      run_xact(1'b1, waddr, wd, 8'hFF, 0, 0);
    end else begin
      awvalid = 1'b0; wvalid = 1'b0;
      run_xact(1'b0, raddr, 64'h0, 8'h00, 1, 0);
    end
  endtask

  initial begin
    int n;
    logic [63:0] d;
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_stb", 64'(wb_stb), 64'd0);
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_adr", 64'(wb_adr), 64'd0);
    chk("rst_dat_o", wb_dat_o, 64'd0);
    chk("rst_sel", 64'(wb_sel), 64'd0);
    chk("rst_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_resp", 64'({bresp, rresp}), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("idle_readies", 64'({awready, wready, arready}), 64'd0);

    // Arbitration straight out of reset: write, read, write, read
    for (int i = 0; i < 4; i++)
      tie_round(40'h00_0000_0100 + 40'(i * 8), {$urandom, $urandom}, 40'h00_0000_0200 + 40'(i * 8));

    // Directed single write and single read
    run_xact(1'b1, 40'h00_0000_0010, 64'h1122334455667788, 8'hFF, 0, 0);
    wb_mem[37'h1]  = 64'hDEADBEEF_CAFEF00D;
    ref_mem[37'h1] = 64'hDEADBEEF_CAFEF00D;
    run_xact(1'b0, 40'h00_0000_0008, 64'h0, 8'h00, 3, 0);
    run_xact(1'b0, 40'h00_0000_0010, 64'h0, 8'h00, 0, 0);

    // Zero strobe still issues a write; response held with bready low
    run_xact(1'b1, 40'h00_0000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 10);
    run_xact(1'b0, 40'h00_0000_001F, 64'h0, 8'h00, 0, 2);

    // Randomized mix against the reference memory
    for (int i = 0; i < 30; i++) begin
      run_xact(1'($urandom_range(0, 1)),
               40'hA5_0000_0000 | 40'($urandom_range(0, 7) << 3) | 40'($urandom_range(0, 7)),
               {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Strobe without ack
    araddr = 40'h00_0000_0040; arvalid = 1'b1;
    #1;
    chk("to_accept", 64'(arready), 64'd1);
    @(posedge aclk); #1; arvalid = 1'b0; #1;
    n = 0;
    while (wb_stb && n < 40) begin n++; @(posedge aclk); #2; end
`ifdef AXI4L_TO_WISHBONE_TIMEOUT_EN
    chk("to_stb_cycles", 64'(n), 64'd16);
    chk("to_rvalid", 64'(rvalid), 64'd1);
    chk("to_rresp", 64'(rresp), 64'd2);
    chk("to_rdata", rdata, 64'd0);
    wb_ack = 1'b1; wb_dat_i = 64'h1234;
    @(posedge aclk); #1; wb_ack = 1'b0; #1;
    chk("to_late_ack_rdata", rdata, 64'd0);
    chk("to_late_ack_rresp", 64'(rresp), 64'd2);
`else
    chk("no_to_stb_cycles", 64'(n), 64'd40);
    chk("no_to_rvalid", 64'(rvalid), 64'd0);
    d = 64'h0BAD_F00D_0000_0001;
    wb_dat_i = d; wb_ack = 1'b1;
    @(posedge aclk); #1; wb_ack = 1'b0; #1;
    chk("no_to_rvalid_after_ack", 64'(rvalid), 64'd1);
    chk("no_to_rdata", rdata, d);
    chk("no_to_rresp", 64'(rresp), 64'd0);
`endif
    rready = 1'b1;
    @(posedge aclk); #1; rready = 1'b0; #1;
    chk("to_done", 64'(rvalid), 64'd0);

    // Reset in the middle of a read
    araddr = 40'h00_0000_0048; arvalid = 1'b1;
    #1;
    chk("rst_mid_accept", 64'(arready), 64'd1);
    @(posedge aclk); #1; arvalid = 1'b0;
    @(posedge aclk); #2;
    chk("rst_mid_stb_before", 64'(wb_stb), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_mid_stb", 64'(wb_stb), 64'd0);
    chk("rst_mid_valids", 64'({bvalid, rvalid, awready, arready}), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    wb_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge aclk); #2;
      wb_ack = 1'b0;
      chk("rst_mid_quiet", 64'({rvalid, wb_stb}), 64'd0);
    end
    last_rd = 1'b1;
    run_xact(1'b0, 40'h00_0000_0010, 64'h0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
